// File: rtl/main_mem_ctrl.sv
// Main-memory controller sitting below the cache.
// Serves whole-line refills and masked line writes. Every access takes a fixed
// MEM_LATENCY cycles and ends with a one-cycle mem_ack pulse. The backing store
// is an on-chip array of lines.
//
// Handshake: the cache raises mem_req with mem_we/mem_addr/mem_wdata/mem_wmask
// and holds it until it sees mem_ack. The request is accepted at the first
// rising edge in IDLE, and all request fields are latched at that edge. The
// inputs are then ignored until the controller is back in IDLE. mem_ack is high
// for exactly one cycle. On a read, mem_rdata is valid while mem_ack is high and
// holds that value until the next read completes.
module main_mem_ctrl #(
  parameter int WORD_SIZE      = 32,
  parameter int BLOCK_SIZE     = 4,
  parameter int LINE_ADDR_BITS = 10,
  parameter int MEM_LATENCY    = 10
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             mem_req,
  input  logic                             mem_we,
  input  logic [31:0]                      mem_addr,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0]  mem_wdata,
  input  logic [BLOCK_SIZE-1:0]            mem_wmask,
  output logic [WORD_SIZE*BLOCK_SIZE-1:0]  mem_rdata,
  output logic                             mem_ack,
  output logic                             mem_busy,
  output logic [1:0]                       state
);

  localparam int LINE_W   = WORD_SIZE * BLOCK_SIZE;
  localparam int OFF_BITS = $clog2(LINE_W / 8);
  localparam int CW       = $clog2(MEM_LATENCY) + 1;
  localparam int LINES    = 1 << LINE_ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                    st;
  logic [CW-1:0]             cnt;
  logic [LINE_ADDR_BITS-1:0] idx_q;
  logic                      we_q;
  logic [LINE_W-1:0]         wdata_q;
  logic [BLOCK_SIZE-1:0]     wmask_q;
  logic                      do_access;

  logic [LINE_W-1:0] mem_array [0:LINES-1];

  // Byte-offset bits and bits above the line index alias onto the same line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:LINE_ADDR_BITS+OFF_BITS],
                              mem_addr[OFF_BITS-1:0]};

  assign state = st;

  // The access edge is the last BUSY edge. A reset at that edge suppresses it.
  assign do_access = reset && (st == BUSY) && (cnt == '0);

  // Control FSM: accept, count down the latency, perform the access, then pulse ack.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st        <= IDLE;
      cnt       <= '0;
      mem_ack   <= 1'b0;
      mem_busy  <= 1'b0;
      mem_rdata <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
    end else begin
      case (st)
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            if (!we_q) mem_rdata <= mem_array[idx_q];
            st      <= ACK;
            mem_ack <= 1'b1;
          end
        end
        ACK: begin
          st       <= IDLE;
          mem_ack  <= 1'b0;
          mem_busy <= 1'b0;
        end
        // IDLE and the unused encoding both behave as IDLE.
        default: begin
          st       <= IDLE;
          mem_ack  <= 1'b0;
          mem_busy <= 1'b0;
          if (mem_req) begin
            idx_q    <= mem_addr[LINE_ADDR_BITS+OFF_BITS-1:OFF_BITS];
            we_q     <= mem_we;
            wdata_q  <= mem_wdata;
            wmask_q  <= mem_wmask;
            cnt      <= CW'(MEM_LATENCY - 1);
            st       <= BUSY;
            mem_busy <= 1'b1;
          end
        end
      endcase
    end
  end

  // Line store: per-word masked write at the access edge. Unmasked words keep their contents.
  always_ff @(posedge clk) begin
    if (do_access && we_q) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        if (wmask_q[i]) mem_array[idx_q][i*WORD_SIZE +: WORD_SIZE] <= wdata_q[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Bench for main_mem_ctrl. It uses a transaction-level reference model, a
// per-cycle output compare, directed cases with literal expectations, and
// randomized traffic. A second instance with MEM_LATENCY=1 covers the
// minimum-latency case.
module tb_main_mem_ctrl;

  localparam int L = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         req, we;
  logic [31:0]  addr;
  logic [127:0] wdata;
  logic [3:0]   wmask;
  logic [127:0] rdata;
  logic         ack, busy;
  logic [1:0]   state;

  logic         req1, we1;
  logic [31:0]  addr1;
  logic [127:0] wdata1;
  logic [3:0]   wmask1;
  logic [127:0] rdata1;
  logic         ack1, busy1;
  logic [1:0]   state1;

  main_mem_ctrl #(.MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .mem_req(req), .mem_we(we), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wmask(wmask), .mem_rdata(rdata), .mem_ack(ack),
    .mem_busy(busy), .state(state)
  );

  main_mem_ctrl #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_wmask(wmask1), .mem_rdata(rdata1), .mem_ack(ack1),
    .mem_busy(busy1), .state(state1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model tracks a transaction by the edge at which it was accepted.
  // Phases 0..L-1 after acceptance are BUSY, phase L is the access edge and
  // enters ACK, and phase L+1 returns to IDLE.
  logic [127:0] m_mem [int];
  logic [1:0]   exp_state;
  logic         exp_ack, exp_busy;
  logic [127:0] exp_rdata;
  bit           m_active = 0;
  int           m_cyc = 0, m_tacc = 0;
  int           m_idx;
  logic         m_we;
  logic [127:0] m_wdata;
  logic [3:0]   m_mask;

  function automatic logic [127:0] m_line(input int i);
    if (m_mem.exists(i)) return m_mem[i];
    return 'x;
  endfunction

  always @(posedge clk) begin
    m_cyc++;
    if (!reset) begin
      m_active = 0;
      exp_state = 2'd0; exp_ack = 0; exp_busy = 0; exp_rdata = '0;
    end else if (!m_active) begin
      exp_ack = 0;
      if (req) begin
        m_active = 1; m_tacc = m_cyc;
        m_idx = int'((addr >> 4) % 1024);
        m_we = we; m_wdata = wdata; m_mask = wmask;
        exp_state = 2'd1; exp_busy = 1;
      end else begin
        exp_state = 2'd0; exp_busy = 0;
      end
    end else if (m_cyc - m_tacc < L) begin
      exp_state = 2'd1; exp_busy = 1; exp_ack = 0;
    end else if (m_cyc - m_tacc == L) begin
      if (m_we) begin
        logic [127:0] line;
        line = m_line(m_idx);
        for (int w = 0; w < 4; w++)
          if (m_mask[w]) line[32*w +: 32] = m_wdata[32*w +: 32];
        m_mem[m_idx] = line;
      end else begin
        exp_rdata = m_line(m_idx);
      end
      exp_state = 2'd2; exp_busy = 1; exp_ack = 1;
    end else begin
      m_active = 0;
      exp_state = 2'd0; exp_busy = 0; exp_ack = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", {126'd0, state}, {126'd0, exp_state});
      chk("ack",   {127'd0, ack},   {127'd0, exp_ack});
      chk("busy",  {127'd0, busy},  {127'd0, exp_busy});
      chk("rdata", rdata, exp_rdata);
    end
  end

  // ---------------- driver ----------------
  // scramble: 0 = hold the inputs, 1 = randomize them while busy, 2 = switch to a read of 0x20.
  task automatic access(input logic w, input logic [31:0] a, input logic [127:0] d,
                        input logic [3:0] m, input int scramble,
                        output int ack_edge, output logic [127:0] rd);
    int k;
    bit got;
    @(negedge clk);
    req = 1; we = w; addr = a; wdata = d; wmask = m;
    @(posedge clk);
    k = 0; got = 0;
    while (k < 100 && !got) begin
      @(negedge clk);
      k++;
      if (ack) got = 1;
      else if (scramble == 1) begin
        addr = $urandom; we = 1'($urandom); wdata = {$urandom, $urandom, $urandom, $urandom};
        wmask = 4'($urandom);
      end else if (scramble == 2) begin
        addr = 32'h20; we = 0;
      end
    end
    chk("ack_seen", {127'd0, got}, 128'd1);
    ack_edge = k - 1;
    rd = rdata;
    req = 0;
  endtask

  int           e;
  logic [127:0] rd;
  logic [127:0] line_val [4];

  initial begin
    // Reset is held low for two edges with a request pending.
    reset = 0; req = 1; we = 1; addr = 32'hff0; wdata = 128'h77; wmask = 4'hf;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; wmask1 = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_state", {126'd0, state}, 128'd0);
    chk("rst_busy",  {127'd0, busy}, 128'd0);
    chk("rst_ack",   {127'd0, ack}, 128'd0);
    chk("rst_rdata", rdata, 128'd0);
    chk_en = 1;
    reset = 1; req = 0;
    @(negedge clk);
    chk("rst_no_accept", {126'd0, state}, 128'd0);

    // Full-line write: ack is expected at edge E10.
    access(1, 32'hff0, 128'h77, 4'hf, 0, e, rd);
    chk("wr_ack_edge", e, L);
    chk("model_pin_77", m_line(255), 128'h77);
    access(0, 32'hff0, '0, 4'h0, 0, e, rd);
    chk("rd_ff0", rd, 128'h00000000_00000000_00000000_00000077);
    chk("rd_ack_edge", e, L);
    access(0, 32'h10ff0, '0, 4'h0, 0, e, rd);
    chk("rd_alias_hi", rd, 128'h77);
    access(0, 32'hffc, '0, 4'h0, 0, e, rd);
    chk("rd_alias_lo", rd, 128'h77);

    // Masked write updates word 0 only.
    access(1, 32'hff0, 128'h11111111_22222222_33333333_00000088, 4'b0001, 0, e, rd);
    chk("model_pin_88", m_line(255), 128'h88);
    access(0, 32'hff0, '0, 4'h0, 0, e, rd);
    chk("rd_masked", rd, 128'h88);
    // A zero mask is a no-op that still acks.
    access(1, 32'hff0, 128'hffff, 4'b0000, 0, e, rd);
    chk("nomask_ack_edge", e, L);

    // Inputs change while busy: the latched write to 0xff0 must win and line 2 must stay untouched.
    access(1, 32'h20, 128'h5555, 4'hf, 0, e, rd);
    access(1, 32'hff0, 128'h88, 4'hf, 2, e, rd);
    chk("hold_ack_edge", e, L);
    access(0, 32'h20, '0, 4'h0, 0, e, rd);
    chk("hold_line2", rd, 128'h5555);

    // Abort: reset is pulled low at edge E5 of a write.
    @(negedge clk);
    req = 1; we = 1; addr = 32'hff0; wdata = 128'hdead; wmask = 4'hf;
    @(posedge clk);
    repeat (5) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("abort_state", {126'd0, state}, 128'd0);
    chk("abort_ack", {127'd0, ack}, 128'd0);
    reset = 1; req = 0;
    access(0, 32'hff0, '0, 4'h0, 0, e, rd);
    chk("abort_prior", rd, 128'h88);

    // Randomized traffic over lines 0x10..0x13 with random aliases, masks, gaps and input noise.
    for (int i = 0; i < 4; i++) begin
      line_val[i] = {$urandom, $urandom, $urandom, $urandom};
      access(1, 32'((16 + i) << 4), line_val[i], 4'hf, 0, e, rd);
    end
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = ($urandom & 32'hffffc000) | 32'((16 + $urandom_range(0, 3)) << 4) | ($urandom & 32'hf);
      access(1'($urandom), a, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom),
             int'($urandom_range(0, 1)), e, rd);
      chk("rand_ack_edge", e, L);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Minimum latency: ack is visible in the cycle after E1.
    chk_en = 0;
    @(negedge clk);
    req1 = 1; we1 = 1; addr1 = 32'h30; wdata1 = 128'habc; wmask1 = 4'hf;
    @(posedge clk);
    @(negedge clk);
    chk("l1_busy_state", {126'd0, state1}, 128'd1);
    chk("l1_no_early_ack", {127'd0, ack1}, 128'd0);
    @(negedge clk);
    chk("l1_ack", {127'd0, ack1}, 128'd1);
    chk("l1_ack_state", {126'd0, state1}, 128'd2);
    req1 = 0;
    @(negedge clk);
    chk("l1_idle", {126'd0, state1}, 128'd0);
    chk("l1_ack_drop", {127'd0, ack1}, 128'd0);
    req1 = 1; we1 = 0;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("l1_rd_ack", {127'd0, ack1}, 128'd1);
    chk("l1_rdata", rdata1, 128'habc);
    req1 = 0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
